// File: rtl/dcache_pkg.sv
// ============================================================================
// Module   : dcache_pkg
// Purpose  : Shared types and geometry defaults for the direct-mapped D-cache.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dcache_pkg;

    localparam int c_def_line_addr_len = 3;
    localparam int c_def_set_addr_len  = 4;
    localparam int c_addr_w            = 32;
    localparam int c_byte_off_w        = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } state_t;

    function automatic int tag_len(input int line_len, input int set_len);
        return c_addr_w - c_byte_off_w - line_len - set_len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_data_array.sv
// ============================================================================
// Module   : dcache_data_array
// Purpose  : Tag/valid/dirty/word storage with combinational reads and
//            synchronous word and line-metadata writes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache_data_array
    import dcache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = c_def_line_addr_len,
    parameter int SET_ADDR_LEN  = c_def_set_addr_len,
    parameter int TAG_LEN       = tag_len(LINE_ADDR_LEN, SET_ADDR_LEN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SET_ADDR_LEN-1:0]  set,
    input  logic [LINE_ADDR_LEN-1:0] rd_off_a,
    input  logic [LINE_ADDR_LEN-1:0] rd_off_b,
    output logic [31:0]              rd_word_a,
    output logic [31:0]              rd_word_b,
    output logic                     rd_valid,
    output logic                     rd_dirty,
    output logic [TAG_LEN-1:0]       rd_tag,
    input  logic                     word_we,
    input  logic [LINE_ADDR_LEN-1:0] word_off,
    input  logic [31:0]              word_data,
    input  logic                     meta_we,
    input  logic                     meta_valid,
    input  logic                     meta_dirty,
    input  logic [TAG_LEN-1:0]       meta_tag
);

    localparam int c_sets  = 1 << SET_ADDR_LEN;
    localparam int c_words = 1 << LINE_ADDR_LEN;

    logic [31:0]        words_q [c_sets][c_words];
    logic [TAG_LEN-1:0] tags_q  [c_sets];
    logic [c_sets-1:0]  valid_q, valid_d;
    logic [c_sets-1:0]  dirty_q, dirty_d;

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (meta_we) begin
            valid_d[set] = meta_valid;
            dirty_d[set] = meta_dirty;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Payload arrays keep their contents across reset; only valid/dirty clear.
    always_ff @(posedge clk) begin
        if (word_we) words_q[set][word_off] <= word_data;
        if (meta_we) tags_q[set]            <= meta_tag;
    end

    assign rd_word_a = words_q[set][rd_off_a];
    assign rd_word_b = words_q[set][rd_off_b];
    assign rd_valid  = valid_q[set];
    assign rd_dirty  = dirty_q[set];
    assign rd_tag    = tags_q[set];

endmodule

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ============================================================================
// Module   : dcache_ctrl
// Purpose  : Direct-mapped write-back/write-allocate D-cache controller with
//            word-serial writeback/refill FSM and access/miss counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = c_def_line_addr_len,
    parameter int SET_ADDR_LEN  = c_def_set_addr_len
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_rd_req,
    output logic        mem_wr_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_gnt,
    output logic [31:0] access_cnt,
    output logic [31:0] miss_cnt
);

    localparam int TAG_LEN = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam logic [LINE_ADDR_LEN-1:0] c_last_word = '1;

    logic [LINE_ADDR_LEN-1:0] w_off;
    logic [SET_ADDR_LEN-1:0]  w_set;
    logic [TAG_LEN-1:0]       w_tag;
    logic                     w_unused_ok;

    assign w_off       = addr[2 +: LINE_ADDR_LEN];
    assign w_set       = addr[2 + LINE_ADDR_LEN +: SET_ADDR_LEN];
    assign w_tag       = addr[31 -: TAG_LEN];
    assign w_unused_ok = &{1'b0, addr[1:0]};

    state_t                   state_q, state_d;
    logic [LINE_ADDR_LEN-1:0] cnt_q, cnt_d;
    logic                     mem_rd_req_q, mem_rd_req_d;
    logic                     mem_wr_req_q, mem_wr_req_d;
    logic [31:0]              mem_addr_q, mem_addr_d;
    logic [31:0]              mem_wdata_q, mem_wdata_d;
    logic [31:0]              access_cnt_q, access_cnt_d;
    logic [31:0]              miss_cnt_q, miss_cnt_d;

    logic                     w_req, w_hit;
    logic                     w_line_valid, w_line_dirty;
    logic [TAG_LEN-1:0]       w_line_tag;
    logic [31:0]              w_word_hit, w_word_wb;
    logic                     w_word_we, w_meta_we, w_meta_dirty;
    logic [LINE_ADDR_LEN-1:0] w_word_off;
    logic [31:0]              w_word_data;

    dcache_data_array #(
        .LINE_ADDR_LEN (LINE_ADDR_LEN),
        .SET_ADDR_LEN  (SET_ADDR_LEN),
        .TAG_LEN       (TAG_LEN)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .set        (w_set),
        .rd_off_a   (w_off),
        .rd_off_b   (cnt_d),
        .rd_word_a  (w_word_hit),
        .rd_word_b  (w_word_wb),
        .rd_valid   (w_line_valid),
        .rd_dirty   (w_line_dirty),
        .rd_tag     (w_line_tag),
        .word_we    (w_word_we),
        .word_off   (w_word_off),
        .word_data  (w_word_data),
        .meta_we    (w_meta_we),
        .meta_valid (1'b1),
        .meta_dirty (w_meta_dirty),
        .meta_tag   (w_tag)
    );

    assign w_req   = rd_req | wr_req;
    assign w_hit   = w_req & w_line_valid & (w_line_tag == w_tag) & (state_q == IDLE);
    assign miss    = w_req & ~w_hit;
    assign rd_data = (w_hit & ~wr_req) ? w_word_hit : 32'd0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        access_cnt_d = access_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        w_word_we    = 1'b0;
        w_word_off   = w_off;
        w_word_data  = wr_data;
        w_meta_we    = 1'b0;
        w_meta_dirty = 1'b0;
        if (w_hit) access_cnt_d = access_cnt_q + 32'd1;
        case (state_q)
            IDLE: begin
                if (w_hit && wr_req) begin
                    w_word_we    = 1'b1;
                    w_meta_we    = 1'b1;
                    w_meta_dirty = 1'b1;
                end else if (miss) begin
                    miss_cnt_d = miss_cnt_q + 32'd1;
                    cnt_d      = '0;
                    state_d    = (w_line_valid && w_line_dirty) ? WB : FILL;
                end
            end
            WB: begin
                if (mem_gnt) begin
                    if (cnt_q == c_last_word) begin
                        cnt_d   = '0;
                        state_d = FILL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FILL: begin
                if (mem_gnt) begin
                    w_word_we   = 1'b1;
                    w_word_off  = cnt_q;
                    w_word_data = mem_rdata;
                    if (cnt_q == c_last_word) begin
                        w_meta_we = 1'b1;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory-side outputs follow the next state/counter so the registered
    // address always names the word the current grant transfers.
    always_comb begin
        mem_rd_req_d = (state_d == FILL);
        mem_wr_req_d = (state_d == WB);
        mem_addr_d   = 32'd0;
        mem_wdata_d  = 32'd0;
        if (state_d == WB) begin
            mem_addr_d  = {w_line_tag, w_set, cnt_d, 2'b00};
            mem_wdata_d = w_word_wb;
        end else if (state_d == FILL) begin
            mem_addr_d  = {w_tag, w_set, cnt_d, 2'b00};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mem_rd_req_q <= 1'b0;
            mem_wr_req_q <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            access_cnt_q <= 32'd0;
            miss_cnt_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_rd_req_q <= mem_rd_req_d;
            mem_wr_req_q <= mem_wr_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            access_cnt_q <= access_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign mem_rd_req = mem_rd_req_q;
    assign mem_wr_req = mem_wr_req_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign access_cnt = access_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

`default_nettype wire
